// File: rtl/router_fifo.sv
// Per-destination router output buffer: DEPTH x {hdr, data} FIFO with a header-driven packet counter for the last-byte flag.
// Read data is registered one edge after an accepted re; writes are dropped while full and reads are ignored while empty.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  input  logic             we,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] din,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             dout_last,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [6:0]  CNT_ONE = 7'd1;

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [6:0]       pkt_cnt;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH:0]   rd_word;
  logic             rd_hdr;
  logic [WIDTH-1:0] rd_data;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A flush wins over both ports, so neither side may advance during soft_rst.
  assign wr_acc = we && !full && !soft_rst;
  assign rd_acc = re && !empty && !soft_rst;

  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign rd_hdr  = rd_word[WIDTH];
  assign rd_data = rd_word[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, din};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (soft_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Header length field counts payload bytes; +1 covers the trailing parity byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      pkt_cnt   <= '0;
    end else if (soft_rst) begin
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      dout_vld  <= rd_acc;
      dout_last <= 1'b0;
      if (rd_acc) begin
        dout <= rd_data;
        if (rd_hdr) begin
          pkt_cnt <= {1'b0, rd_data[7:2]} + CNT_ONE;
        end else if (pkt_cnt != '0) begin
          pkt_cnt   <= pkt_cnt - CNT_ONE;
          dout_last <= (pkt_cnt == CNT_ONE);
        end
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboarded bench for router_fifo: directed packet scenarios followed by random traffic against a queue-based model.
module tb_router_fifo;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       soft_rst;
  logic       we;
  logic       lfd_state;
  logic [7:0] din;
  logic       re;
  logic [7:0] dout;
  logic       dout_vld;
  logic       dout_last;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  // Reference state: stored words as {hdr, data}, expected reads as {last, data}.
  logic [8:0] fifo_q [$];
  logic [8:0] exp_q  [$];
  int         remaining = 0;

  router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .we(we), .lfd_state(lfd_state),
    .din(din), .re(re), .dout(dout), .dout_vld(dout_vld), .dout_last(dout_last),
    .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every output pulse must match the next expected read.
  always @(negedge clk) begin
    if (dout_vld) begin
      logic [8:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vld: got dout %0h with nothing expected at %0t", dout, $time);
      end else begin
        e = exp_q.pop_front();
        if (dout != e[7:0] || dout_last != e[8]) begin
          errors++;
          $display("FAIL read_data: got dout %0h last %0b expected dout %0h last %0b at %0t",
                   dout, dout_last, e[7:0], e[8], $time);
        end
      end
    end else if (dout_last) begin
      checks++;
      errors++;
      $display("FAIL last_without_vld: got dout_last 1 expected 0 at %0t", $time);
    end
  end

  task automatic step(input logic w, input logic l, input logic [7:0] d,
                      input logic r, input logic s);
    logic acc_w;
    logic acc_r;
    logic [8:0] e;
    logic last;
    we = w; lfd_state = l; din = d; re = r; soft_rst = s;
    acc_w = w && (fifo_q.size() < 16) && !s;
    acc_r = r && (fifo_q.size() > 0) && !s;
    if (s) begin
      fifo_q.delete();
      remaining = 0;
    end else begin
      if (acc_r) begin
        e = fifo_q.pop_front();
        last = 1'b0;
        if (e[8]) begin
          remaining = int'(e[7:2]) + 1;
        end else if (remaining > 0) begin
          remaining--;
          last = (remaining == 0);
        end
        exp_q.push_back({last, e[7:0]});
      end
      if (acc_w) fifo_q.push_back({l, d});
    end
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; soft_rst = 1'b0; lfd_state = 1'b0;
    check("empty_flag", int'(empty), int'(fifo_q.size() == 0));
    check("full_flag", int'(full), int'(fifo_q.size() == 16));
  endtask

  task automatic wr(input logic l, input logic [7:0] d);
    step(1'b1, l, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    clk_en = 1'b0;
    rst = 1'b1; soft_rst = 1'b0; we = 1'b0; lfd_state = 1'b0; din = '0; re = 1'b0;
    #12;
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_vld", int'(dout_vld), 0);
    #8;
    rst = 1'b0;
    clk_en = 1'b1;

    // Read while empty must not produce a pulse.
    rd();
    check("empty_read_vld", int'(dout_vld), 0);

    // Packet round trip: header length 3, three payload bytes, parity.
    wr(1'b1, 8'h0D); wr(1'b0, 8'hA1); wr(1'b0, 8'hA2); wr(1'b0, 8'hA3); wr(1'b0, 8'hAD);
    repeat (5) rd();
    idle();

    // Fill, overflow write dropped, drain in order.
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h30 + i));
    wr(1'b0, 8'hFF);
    repeat (16) rd();

    // Simultaneous read/write at full, then at half occupancy.
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h50 + i));
    step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
    repeat (7) rd();
    step(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
    check("half_not_empty", int'(empty), 0);
    repeat (8) rd();
    idle();

    // Soft reset mid-packet together with a write.
    wr(1'b1, 8'h11); wr(1'b0, 8'h21); wr(1'b0, 8'h22);
    rd();
    step(1'b1, 1'b0, 8'h7E, 1'b0, 1'b1);
    check("srst_dout", int'(dout), 0);
    check("srst_vld", int'(dout_vld), 0);
    wr(1'b1, 8'h05); wr(1'b0, 8'h33); wr(1'b0, 8'h44);
    repeat (3) rd();
    idle();

    // Length-0 packet, then truncated packet followed by a new header.
    wr(1'b1, 8'h02); wr(1'b0, 8'h02);
    rd(); rd();
    wr(1'b1, 8'h0C); wr(1'b0, 8'h61);
    wr(1'b1, 8'h04); wr(1'b0, 8'h62); wr(1'b0, 8'h63);
    repeat (5) rd();
    idle();

    // Asynchronous reset mid-packet.
    wr(1'b1, 8'h08); wr(1'b0, 8'hA5); wr(1'b0, 8'hA6); wr(1'b0, 8'hA7);
    rd(); rd();
    idle();
    rst = 1'b1;
    #1;
    check("arst_dout", int'(dout), 0);
    check("arst_empty", int'(empty), 1);
    fifo_q.delete();
    remaining = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr(1'b0, 8'h77);
    rd();
    idle();

    // Random traffic with phases biased toward filling and draining.
    for (int ph = 0; ph < 6; ph++) begin
      int wp = (ph % 2 == 0) ? 80 : 35;
      for (int i = 0; i < 300; i++) begin
        logic w, r, l, s;
        logic [7:0] d;
        w = ($urandom_range(99) < wp);
        r = ($urandom_range(99) < 100 - wp + 15);
        l = ($urandom_range(99) < 20);
        d = l ? {3'b000, 3'($urandom_range(7)), 2'($urandom_range(3))} : 8'($urandom);
        s = ($urandom_range(999) < 5);
        step(w, l, d, r, s);
      end
    end
    idle();
    idle();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
